// File: rtl/bcd_src_counter.sv
`default_nettype none
// ============================================================================
// Module   : bcd_src_counter
// Brief    : Debounced two-button up/down source counter feeding Binary2BCD.
//            Optional macro BCD_SRC_SATURATE_EN: saturate instead of wrap.
// Revision : 1.0 - initial release
// ============================================================================

module bcd_src_counter #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int MAX_CNT         = 15
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       BtnUp,
  input  logic       BtnDn,
  input  logic       Clr,
  output logic [3:0] Cnt,
  output logic       Wrap
);

  localparam logic [1:0] c_st_released     = 2'd0;
  localparam logic [1:0] c_st_wait_press   = 2'd1;
  localparam logic [1:0] c_st_pressed      = 2'd2;
  localparam logic [1:0] c_st_wait_release = 2'd3;

  localparam logic [7:0] c_deb = 8'(DEBOUNCE_CYCLES);
  localparam logic [3:0] c_max = 4'(MAX_CNT);

  logic [1:0] w_btn_raw;
  logic [1:0] w_step;
  logic       w_up;
  logic       w_dn;
  logic [3:0] r_cnt;
  logic       r_wrap;

  assign w_btn_raw = {BtnDn, BtnUp};

  for (genvar gi = 0; gi < 2; gi++) begin : g_btn
    logic       r_meta;
    logic       r_sync;
    logic [1:0] r_state;
    logic [7:0] r_dcnt;

    always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
        r_meta <= 1'b0;
        r_sync <= 1'b0;
      end else begin
        r_meta <= w_btn_raw[gi];
        r_sync <= r_meta;
      end
    end

    always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
        r_state <= c_st_released;
        r_dcnt  <= 8'd0;
      end else begin
        case (r_state)
          c_st_released: begin
            if (r_sync) begin
              r_state <= c_st_wait_press;
              r_dcnt  <= 8'd1;
            end
          end
          c_st_wait_press: begin
            if (!r_sync) begin
              r_state <= c_st_released;
              r_dcnt  <= 8'd0;
            end else if (r_dcnt == c_deb) begin
              r_state <= c_st_pressed;
              r_dcnt  <= 8'd0;
            end else begin
              r_dcnt <= r_dcnt + 8'd1;
            end
          end
          c_st_pressed: begin
            if (!r_sync) begin
              r_state <= c_st_wait_release;
              r_dcnt  <= 8'd1;
            end
          end
          c_st_wait_release: begin
            // A bounce back high during release returns to PRESSED silently.
            if (r_sync) begin
              r_state <= c_st_pressed;
              r_dcnt  <= 8'd0;
            end else if (r_dcnt == c_deb) begin
              r_state <= c_st_released;
              r_dcnt  <= 8'd0;
            end else begin
              r_dcnt <= r_dcnt + 8'd1;
            end
          end
          default: begin
            r_state <= c_st_released;
            r_dcnt  <= 8'd0;
          end
        endcase
      end
    end

    // Combinational so the count moves on the same edge the press is accepted.
    assign w_step[gi] = (r_state == c_st_wait_press) && r_sync && (r_dcnt == c_deb);
  end

  assign w_up = w_step[0];
  assign w_dn = w_step[1];

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_cnt  <= 4'd0;
      r_wrap <= 1'b0;
    end else begin
      r_wrap <= 1'b0;
      if (Clr) begin
        r_cnt <= 4'd0;
      end else if (w_up && w_dn) begin
        r_cnt <= r_cnt;
      end else if (w_up) begin
        if (r_cnt == c_max) begin
`ifdef BCD_SRC_SATURATE_EN
          r_cnt  <= c_max;
`else
          r_cnt  <= 4'd0;
          r_wrap <= 1'b1;
`endif
        end else begin
          r_cnt <= r_cnt + 4'd1;
        end
      end else if (w_dn) begin
        if (r_cnt == 4'd0) begin
`ifdef BCD_SRC_SATURATE_EN
          r_cnt  <= 4'd0;
`else
          r_cnt  <= c_max;
          r_wrap <= 1'b1;
`endif
        end else begin
          r_cnt <= r_cnt - 4'd1;
        end
      end
    end
  end

  assign Cnt  = r_cnt;
  assign Wrap = r_wrap;

endmodule

`default_nettype wire

// File: tb/tb_bcd_src_counter.sv
`default_nettype none
// ============================================================================
// Module   : tb_bcd_src_counter
// Brief    : Self-checking bench for bcd_src_counter (MAX_CNT 15 and 9 copies).
// Revision : 1.0 - initial release
// ============================================================================

module tb_bcd_src_counter;

  localparam int DEB = 4;
`ifdef BCD_SRC_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  localparam int OP_UP    = 0;
  localparam int OP_DN    = 1;
  localparam int OP_BOTH  = 2;
  localparam int OP_CLRUP = 3;

  typedef struct {
    int cnt;
    bit wrap;
    int cnt9;
    bit wrap9;
  } exp_t;

  typedef struct {
    int op;
    int exp_cnt;
    bit exp_wrap;
  } vec_t;

  logic       Clk;
  logic       Rst;
  logic       BtnUp;
  logic       BtnDn;
  logic       Clr;
  logic [3:0] Cnt;
  logic       Wrap;
  logic [3:0] cnt9;
  logic       wrap9;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   m_cnt    = 0;
  int   m9       = 0;
  bit   done     = 1'b0;
  exp_t sb[$];
  vec_t tbl[7];

  bcd_src_counter #(.DEBOUNCE_CYCLES(DEB), .MAX_CNT(15)) dut (
    .Clk(Clk), .Rst(Rst), .BtnUp(BtnUp), .BtnDn(BtnDn), .Clr(Clr),
    .Cnt(Cnt), .Wrap(Wrap)
  );

  bcd_src_counter #(.DEBOUNCE_CYCLES(DEB), .MAX_CNT(9)) dut9 (
    .Clk(Clk), .Rst(Rst), .BtnUp(BtnUp), .BtnDn(BtnDn), .Clr(Clr),
    .Cnt(cnt9), .Wrap(wrap9)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // The nine-count copy must never present a value outside 0..9.
  always @(negedge Clk) begin
    if (!Rst && !done) begin
      n_checks++;
      if (cnt9 > 4'd9) begin
        n_fail++;
        $display("FAIL range9: got %0d required <= 9", cnt9);
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void model(input int c, input int maxv, input bit up,
                                input bit dn, input bit clr,
                                output int nc, output bit w);
    nc = c;
    w  = 1'b0;
    if (clr) nc = 0;
    else if (up && dn) nc = c;
    else if (up) begin
      if (c == maxv) begin
        nc = SAT ? maxv : 0;
        w  = !SAT;
      end else nc = c + 1;
    end else if (dn) begin
      if (c == 0) begin
        nc = SAT ? 0 : maxv;
        w  = !SAT;
      end else nc = c - 1;
    end
  endfunction

  function automatic exp_t predict(input bit up, input bit dn, input bit clr);
    exp_t e;
    model(m_cnt, 15, up, dn, clr, e.cnt, e.wrap);
    model(m9, 9, up, dn, clr, e.cnt9, e.wrap9);
    return e;
  endfunction

  task automatic compare_pop(input string tag);
    exp_t got;
    if (sb.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: scoreboard empty", tag);
    end else begin
      got = sb.pop_front();
      check({tag, "_cnt"}, int'(Cnt), got.cnt);
      check({tag, "_wrap"}, int'(Wrap), int'(got.wrap));
      check({tag, "_cnt9"}, int'(cnt9), got.cnt9);
      check({tag, "_wrap9"}, int'(wrap9), int'(got.wrap9));
    end
  endtask

  // Starts and ends on a falling edge; a full clean press and release.
  task automatic apply(input int op, input bit use_tbl, input int tcnt, input bit twrap);
    exp_t e;
    int   pc;
    int   pc9;
    bit   up;
    bit   dn;
    bit   clr;
    up  = (op == OP_UP) || (op == OP_BOTH) || (op == OP_CLRUP);
    dn  = (op == OP_DN) || (op == OP_BOTH);
    clr = (op == OP_CLRUP);
    pc  = m_cnt;
    pc9 = m9;
    e   = predict(up, dn, clr);
    if (use_tbl) begin
      e.cnt  = tcnt;
      e.wrap = twrap;
    end
    m_cnt = e.cnt;
    m9    = e.cnt9;
    sb.push_back(e);
    BtnUp = up;
    BtnDn = dn;
    repeat (DEB + 2) @(posedge Clk);
    #1;
    check("early_cnt", int'(Cnt), pc);
    check("early_cnt9", int'(cnt9), pc9);
    Clr = clr;
    @(posedge Clk);
    #1;
    Clr = 1'b0;
    compare_pop("step");
    @(posedge Clk);
    #1;
    check("wrap_pulse_len", int'(Wrap), 0);
    check("wrap9_pulse_len", int'(wrap9), 0);
    check("hold_cnt", int'(Cnt), e.cnt);
    BtnUp = 1'b0;
    BtnDn = 1'b0;
    repeat (DEB + 4) @(posedge Clk);
    #1;
    check("release_cnt", int'(Cnt), e.cnt);
    check("release_cnt9", int'(cnt9), e.cnt9);
    @(negedge Clk);
  endtask

  task automatic do_clr();
    exp_t e;
    e     = predict(1'b0, 1'b0, 1'b1);
    m_cnt = e.cnt;
    m9    = e.cnt9;
    sb.push_back(e);
    Clr = 1'b1;
    @(posedge Clk);
    #1;
    Clr = 1'b0;
    compare_pop("clr");
    @(negedge Clk);
  endtask

  initial begin
    exp_t e;
    tbl[0] = '{OP_UP,   1, 1'b0};
    tbl[1] = '{OP_UP,   2, 1'b0};
    tbl[2] = '{OP_DN,   1, 1'b0};
    tbl[3] = '{OP_DN,   0, 1'b0};
    tbl[4] = '{OP_DN,   SAT ? 0 : 15, !SAT};
    tbl[5] = '{OP_UP,   SAT ? 1 : 0,  !SAT};
    tbl[6] = '{OP_BOTH, SAT ? 1 : 0,  1'b0};

    Rst   = 1'b1;
    BtnUp = 1'b0;
    BtnDn = 1'b0;
    Clr   = 1'b0;
    repeat (3) @(negedge Clk);
    check("reset_cnt", int'(Cnt), 0);
    check("reset_wrap", int'(Wrap), 0);
    check("reset_cnt9", int'(cnt9), 0);
    Rst = 1'b0;
    @(negedge Clk);

    for (int i = 0; i < 7; i++) apply(tbl[i].op, 1'b1, tbl[i].exp_cnt, tbl[i].exp_wrap);

    // Simultaneous presses from 7 leave the count alone.
    do_clr();
    repeat (7) apply(OP_UP, 1'b0, 0, 1'b0);
    apply(OP_BOTH, 1'b0, 0, 1'b0);
    check("both_from_7", int'(Cnt), 7);

    // Clear wins over an up step landing on the same edge.
    do_clr();
    repeat (9) apply(OP_UP, 1'b0, 0, 1'b0);
    apply(OP_CLRUP, 1'b0, 0, 1'b0);

    // Asynchronous reset mid-cycle at 5, button held through reset.
    repeat (5) apply(OP_UP, 1'b0, 0, 1'b0);
    #2;
    Rst   = 1'b1;
    BtnUp = 1'b1;
    #1;
    check("async_rst_cnt", int'(Cnt), 0);
    check("async_rst_wrap", int'(Wrap), 0);
    check("async_rst_cnt9", int'(cnt9), 0);
    @(negedge Clk);
    @(negedge Clk);
    Rst   = 1'b0;
    m_cnt = 0;
    m9    = 0;
    sb.delete();
    apply(OP_UP, 1'b0, 0, 1'b0);

    // Bouncy press: only the final stable hold counts, once.
    for (int i = 0; i < 5; i++) begin
      BtnUp = 1'b1;
      repeat (2) @(negedge Clk);
      BtnUp = 1'b0;
      repeat (2) @(negedge Clk);
    end
    check("bounce_reject", int'(Cnt), m_cnt);
    e     = predict(1'b1, 1'b0, 1'b0);
    m_cnt = e.cnt;
    m9    = e.cnt9;
    sb.push_back(e);
    BtnUp = 1'b1;
    repeat (10) @(posedge Clk);
    #1;
    compare_pop("bounce_step");
    repeat (50) @(posedge Clk);
    #1;
    check("long_hold_cnt", int'(Cnt), m_cnt);
    BtnUp = 1'b0;
    repeat (DEB + 4) @(negedge Clk);

    // Preload to the top and step past it.
    do_clr();
    repeat (15) apply(OP_UP, 1'b0, 0, 1'b0);
    check("preload_15", int'(Cnt), 15);
    apply(OP_UP, 1'b0, 0, 1'b0);
    check("wrap_up_final", int'(Cnt), SAT ? 15 : 0);

    // Ten presses on the nine-count copy.
    do_clr();
    repeat (10) apply(OP_UP, 1'b0, 0, 1'b0);
    check("max9_final", int'(cnt9), SAT ? 9 : 0);

    done = 1'b1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
